// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
// Front-end controller between the serial pixel stream and the conv/classifier
// datapath. Accepts one IMG_W x IMG_H frame in raster order, writes each pixel
// into the line buffer with its coordinates, flags every pixel that completes a
// KxK window, lets the conv pipeline drain, starts the fully-connected stage,
// and presents the classifier result. New pixels are refused from the end of
// the frame until the result has been issued.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   pixel_i/_valid      input pixel and qualifier
//   pixel_i_ready       sequencer accepts a pixel this cycle (IDLE/LOAD)
//   lb_wr_en/_data      line-buffer write strobe and pixel
//   lb_row, lb_col      coordinates of the written pixel
//   win_valid           a complete KxK window ends at the written pixel
//   win_row, win_col    output-map coordinates of that window (0 otherwise)
//   fc_start            one-cycle start pulse to the classifier
//   fc_done, fc_digit   classifier result strobe and value
//   digit_o/_valid      last classified digit and its one-cycle strobe
//   busy                high in any state other than IDLE
// -----------------------------------------------------------------------------
module frame_sequencer #(
   parameter int IMG_W     = 30,
   parameter int IMG_H     = 30,
   parameter int K         = 3,
   parameter int DRAIN_CYC = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] pixel_i,
   input  logic       pixel_i_valid,
   output logic       pixel_i_ready,
   output logic       lb_wr_en,
   output logic [7:0] lb_wr_data,
   output logic [4:0] lb_row,
   output logic [4:0] lb_col,
   output logic       win_valid,
   output logic [4:0] win_row,
   output logic [4:0] win_col,
   output logic       fc_start,
   input  logic       fc_done,
   input  logic [3:0] fc_digit,
   output logic [3:0] digit_o,
   output logic       digit_o_valid,
   output logic       busy
);

   localparam logic [4:0] COL_LAST = 5'(IMG_W - 1);
   localparam logic [4:0] ROW_LAST = 5'(IMG_H - 1);
   localparam logic [4:0] WIN_OFS  = 5'(K - 1);
   localparam int         DCW      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_CLASSIFY,
      S_OUTPUT
   } state_t;

   state_t           state_q, state_d;
   logic [4:0]       row_q, row_d;
   logic [4:0]       col_q, col_d;
   logic [DCW-1:0]   drain_q, drain_d;
   logic [3:0]       digit_q, digit_d;

   logic             ready_q;
   logic             fc_start_q;
   logic             digit_valid_q;
   logic             lb_wr_en_q;
   logic [7:0]       lb_wr_data_q;
   logic [4:0]       lb_row_q, lb_col_q;
   logic             win_valid_q;
   logic [4:0]       win_row_q, win_col_q;

   logic             accept;
   logic             last_pix;
   logic             win_hit;

   assign accept   = pixel_i_valid & ready_q;
   assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);
   assign win_hit  = (row_q >= WIN_OFS) && (col_q >= WIN_OFS);

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      drain_d = drain_q;
      digit_d = digit_q;

      case (state_q)
         S_IDLE, S_LOAD: begin
            if (accept) begin
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
               end else begin
                  col_d = col_q + 5'd1;
               end
               if (last_pix) begin
                  state_d = S_DRAIN;
                  drain_d = DRAIN_LOAD;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_DRAIN: begin
            if (drain_q == '0) state_d = S_CLASSIFY;
            else               drain_d = drain_q - 1'b1;
         end
         S_CLASSIFY: begin
            // The classifier cannot answer in the cycle it is started, so a
            // done strobe coincident with fc_start is treated as stale.
            if (fc_done && !fc_start_q) begin
               digit_d = fc_digit;
               state_d = S_OUTPUT;
            end
         end
         S_OUTPUT: begin
            row_d   = '0;
            col_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         row_q         <= '0;
         col_q         <= '0;
         drain_q       <= '0;
         digit_q       <= '0;
         ready_q       <= 1'b1;
         fc_start_q    <= 1'b0;
         digit_valid_q <= 1'b0;
         lb_wr_en_q    <= 1'b0;
         lb_wr_data_q  <= '0;
         lb_row_q      <= '0;
         lb_col_q      <= '0;
         win_valid_q   <= 1'b0;
         win_row_q     <= '0;
         win_col_q     <= '0;
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         col_q         <= col_d;
         drain_q       <= drain_d;
         digit_q       <= digit_d;
         // Status strobes are decoded from the next state so they line up
         // with the state register they describe.
         ready_q       <= (state_d == S_IDLE) || (state_d == S_LOAD);
         fc_start_q    <= (state_d == S_CLASSIFY) && (state_q != S_CLASSIFY);
         digit_valid_q <= (state_d == S_OUTPUT);
         lb_wr_en_q    <= accept;
         if (accept) begin
            lb_wr_data_q <= pixel_i;
            lb_row_q     <= row_q;
            lb_col_q     <= col_q;
            win_valid_q  <= win_hit;
            win_row_q    <= win_hit ? row_q - WIN_OFS : 5'd0;
            win_col_q    <= win_hit ? col_q - WIN_OFS : 5'd0;
         end else begin
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
         end
      end
   end

   assign pixel_i_ready = ready_q;
   assign lb_wr_en      = lb_wr_en_q;
   assign lb_wr_data    = lb_wr_data_q;
   assign lb_row        = lb_row_q;
   assign lb_col        = lb_col_q;
   assign win_valid     = win_valid_q;
   assign win_row       = win_row_q;
   assign win_col       = win_col_q;
   assign fc_start      = fc_start_q;
   assign digit_o       = digit_q;
   assign digit_o_valid = digit_valid_q;
   assign busy          = (state_q != S_IDLE);

endmodule
